uart_tx: RTL and testbench

UART transmitter: serialises bytes onto an asynchronous serial line at a fixed baud rate. It is the transmit end of the board's serial link, complementing the oversampling receive path. It accepts bytes over a valid/ready handshake and holds one byte in a buffer so consecutive frames go out with no idle gap.

---
 rtl/uart_tx.sv | 182 ++++++++++++++++++
 tb/tb_uart_tx.sv | 376 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx.sv
// uart_tx: UART transmitter with a one-byte hold buffer so consecutive frames go out
// back-to-back with no idle gap between the last stop bit and the next start bit.
//
// Parameters:
//   CLK_HZ     system clock frequency in Hz
//   BAUD_RATE  line bit rate; each bit lasts CLK_HZ/BAUD_RATE clocks (must be >= 2)
//   PARITY     0 = none, 1 = odd, 2 = even
//   STOP_BITS  1 or 2
//
// Ports:
//   clk_in     system clock, rising edge
//   rst_in     asynchronous active-high reset
//   data_in    byte to send, sampled on the accept edge (valid_in && ready_out)
//   valid_in   data_in is valid
//   ready_out  a byte can be accepted (hold register empty)
//   tx_out     registered serial line, idle high
//   busy_out   a frame is on the line or a byte is buffered
module uart_tx #(
   parameter int unsigned CLK_HZ    = 100_000_000,
   parameter int unsigned BAUD_RATE = 9600,
   parameter int unsigned PARITY    = 0,
   parameter int unsigned STOP_BITS = 1
) (
   input  logic       clk_in,
   input  logic       rst_in,
   input  logic [7:0] data_in,
   input  logic       valid_in,
   output logic       ready_out,
   output logic       tx_out,
   output logic       busy_out
);

   localparam int unsigned ClksPerBit = CLK_HZ / BAUD_RATE;
   localparam int unsigned TimerW     = $clog2(ClksPerBit);
   localparam logic [TimerW-1:0] TimerReload = TimerW'(ClksPerBit - 1);
   localparam logic LastStop = 1'(STOP_BITS - 1);

   if (PARITY > 2) begin : g_bad_parity
      $error("uart_tx: PARITY must be 0, 1 or 2");
   end
   if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop_bits
      $error("uart_tx: STOP_BITS must be 1 or 2");
   end
   if (ClksPerBit < 2) begin : g_bad_baud
      $error("uart_tx: CLK_HZ/BAUD_RATE must be at least 2");
   end

   typedef enum logic [2:0] {
      StIdle,
      StStart,
      StData,
      StPar,
      StStop
   } state_e;

   state_e            state_q, state_d;
   logic [TimerW-1:0] timer_q, timer_d;
   logic [2:0]        bit_idx_q, bit_idx_d;
   logic              stop_idx_q, stop_idx_d;
   logic [7:0]        shift_q, shift_d;
   logic [7:0]        hold_q, hold_d;
   logic              hold_full_q, hold_full_d;
   logic              tx_q, tx_d;
   logic              accept;
   logic              bit_done;

   assign ready_out = ~hold_full_q;
   assign busy_out  = (state_q != StIdle) || hold_full_q;
   assign tx_out    = tx_q;
   assign accept    = valid_in && ready_out;
   assign bit_done  = (timer_q == '0);

   always_comb begin
      state_d     = state_q;
      timer_d     = timer_q;
      bit_idx_d   = bit_idx_q;
      stop_idx_d  = stop_idx_q;
      shift_d     = shift_q;
      hold_d      = hold_q;
      hold_full_d = hold_full_q;
      tx_d        = 1'b1;

      // Timer sits at its reload value in idle, so a frame start always begins a full bit.
      if (state_q == StIdle || bit_done) begin
         timer_d = TimerReload;
      end else begin
         timer_d = timer_q - TimerW'(1);
      end

      unique case (state_q)
         StIdle: begin
            // A byte that landed in hold on the STOP->IDLE edge starts one cycle later.
            if (hold_full_q) begin
               shift_d     = hold_q;
               hold_full_d = 1'b0;
               bit_idx_d   = '0;
               state_d     = StStart;
            end else if (accept) begin
               shift_d   = data_in;
               bit_idx_d = '0;
               state_d   = StStart;
            end
         end
         StStart: begin
            if (bit_done) begin
               bit_idx_d = '0;
               state_d   = StData;
            end
         end
         StData: begin
            if (bit_done) begin
               if (bit_idx_q == 3'd7) begin
                  stop_idx_d = 1'b0;
                  state_d    = (PARITY != 0) ? StPar : StStop;
               end else begin
                  bit_idx_d = bit_idx_q + 3'd1;
               end
            end
         end
         StPar: begin
            if (bit_done) begin
               stop_idx_d = 1'b0;
               state_d    = StStop;
            end
         end
         StStop: begin
            if (bit_done) begin
               if (stop_idx_q == LastStop) begin
                  if (hold_full_q) begin
                     shift_d     = hold_q;
                     hold_full_d = 1'b0;
                     bit_idx_d   = '0;
                     state_d     = StStart;
                  end else begin
                     state_d = StIdle;
                  end
               end else begin
                  stop_idx_d = 1'b1;
               end
            end
         end
         default: state_d = StIdle;
      endcase

      // ready_out is low while hold is full, so this never collides with a hold transfer.
      if (accept && state_q != StIdle) begin
         hold_d      = data_in;
         hold_full_d = 1'b1;
      end

      // Line level is registered from the next state so it changes on the same edge.
      unique case (state_d)
         StStart: tx_d = 1'b0;
         StData:  tx_d = shift_d[bit_idx_d];
         StPar:   tx_d = (PARITY == 2) ? ^shift_d : ~^shift_d;
         default: tx_d = 1'b1;
      endcase
   end

   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         state_q     <= StIdle;
         timer_q     <= TimerReload;
         bit_idx_q   <= '0;
         stop_idx_q  <= 1'b0;
         shift_q     <= '0;
         hold_q      <= '0;
         hold_full_q <= 1'b0;
         tx_q        <= 1'b1;
      end else begin
         state_q     <= state_d;
         timer_q     <= timer_d;
         bit_idx_q   <= bit_idx_d;
         stop_idx_q  <= stop_idx_d;
         shift_q     <= shift_d;
         hold_q      <= hold_d;
         hold_full_q <= hold_full_d;
         tx_q        <= tx_d;
      end
   end

endmodule

// File: tb/tb_uart_tx.sv
// Testbench for uart_tx: four instances (8N1, 8E1, 8O1, 8N2) at 10 clocks per bit.
// Sent bytes are queued per instance; a line monitor pops each byte when its start bit
// appears and checks every cycle of the frame against the expected levels.
module tb_uart_tx;

   localparam int CPB  = 10;
   localparam int NDUT = 4;

   logic       clk_in  = 1'b0;
   logic       rst_in  = 1'b0;
   logic [7:0] data_in = 8'h00;
   logic       valid [NDUT];
   logic       ready [NDUT];
   logic       tx    [NDUT];
   logic       busy  [NDUT];

   int checks = 0;
   int errors = 0;
   int cyc    = 0;
   int busy_cnt    [NDUT] = '{default: 0};
   int frames_done [NDUT] = '{default: 0};
   logic [7:0] sb_q [NDUT][$];

   uart_tx #(.CLK_HZ(1000), .BAUD_RATE(100), .PARITY(0), .STOP_BITS(1)) u_8n1 (
      .clk_in(clk_in), .rst_in(rst_in), .data_in(data_in), .valid_in(valid[0]),
      .ready_out(ready[0]), .tx_out(tx[0]), .busy_out(busy[0]));
   uart_tx #(.CLK_HZ(1000), .BAUD_RATE(100), .PARITY(2), .STOP_BITS(1)) u_8e1 (
      .clk_in(clk_in), .rst_in(rst_in), .data_in(data_in), .valid_in(valid[1]),
      .ready_out(ready[1]), .tx_out(tx[1]), .busy_out(busy[1]));
   uart_tx #(.CLK_HZ(1000), .BAUD_RATE(100), .PARITY(1), .STOP_BITS(1)) u_8o1 (
      .clk_in(clk_in), .rst_in(rst_in), .data_in(data_in), .valid_in(valid[2]),
      .ready_out(ready[2]), .tx_out(tx[2]), .busy_out(busy[2]));
   uart_tx #(.CLK_HZ(1000), .BAUD_RATE(100), .PARITY(0), .STOP_BITS(2)) u_8n2 (
      .clk_in(clk_in), .rst_in(rst_in), .data_in(data_in), .valid_in(valid[3]),
      .ready_out(ready[3]), .tx_out(tx[3]), .busy_out(busy[3]));

   always #5 clk_in = ~clk_in;

   always @(posedge clk_in) cyc <= cyc + 1;

   always @(negedge clk_in) begin
      if (rst_in == 1'b0) begin
         for (int g = 0; g < NDUT; g++) busy_cnt[g] <= busy_cnt[g] + int'(busy[g] === 1'b1);
      end
   end

   // Line monitors: one per instance.
   for (genvar g = 0; g < NDUT; g++) begin : g_mon
      localparam int Par   = (g == 1) ? 2 : (g == 2) ? 1 : 0;
      localparam int Stops = (g == 3) ? 2 : 1;
      initial begin : mon
         logic [7:0] b;
         logic       lv [12];
         logic       act;
         int         n;
         bit         abort;
         bit         ok;
         forever begin
            @(negedge clk_in);
            if (rst_in === 1'b0 && tx[g] === 1'b0) begin
               if (sb_q[g].size() == 0) begin
                  checks++;
                  errors++;
                  $display("FAIL unexpected_frame dut%0d: got start bit at cycle %0d, required idle line",
                           g, cyc);
                  for (int w = 0; w < 300 && busy[g] === 1'b1; w++) @(negedge clk_in);
               end else begin
                  b = sb_q[g].pop_front();
                  lv[0] = 1'b0;
                  for (int i = 0; i < 8; i++) lv[1 + i] = b[i];
                  n = 9;
                  if (Par != 0) begin
                     lv[9] = (Par == 2) ? ^b : ~^b;
                     n = 10;
                  end
                  for (int s = 0; s < Stops; s++) lv[n + s] = 1'b1;
                  n = n + Stops;
                  abort = 1'b0;
                  for (int k = 0; k < n; k++) begin
                     ok  = 1'b1;
                     act = lv[k];
                     for (int c = 0; c < CPB; c++) begin
                        if (k != 0 || c != 0) @(negedge clk_in);
                        if (rst_in !== 1'b0) begin
                           abort = 1'b1;
                           break;
                        end
                        if (tx[g] !== lv[k] && ok) begin
                           ok  = 1'b0;
                           act = tx[g];
                        end
                     end
                     if (abort) break;
                     checks++;
                     if (!ok) begin
                        errors++;
                        $display("FAIL frame_bit dut%0d byte %02h bit %0d: got %b, required %b for %0d cycles",
                                 g, b, k, act, lv[k], CPB);
                     end
                  end
                  if (!abort) frames_done[g]++;
               end
            end
         end
      end
   end

   // Drive one byte; returns the cycle index of the accept edge.
   task automatic send(input int g, input logic [7:0] b, output int acc);
      int w;
      w = 0;
      while (ready[g] !== 1'b1 && w < 500) begin
         @(posedge clk_in);
         #1;
         w++;
      end
      if (ready[g] !== 1'b1) begin
         checks++;
         errors++;
         $display("FAIL send_timeout dut%0d: ready got %b, required 1", g, ready[g]);
         acc = -1;
         return;
      end
      data_in  = b;
      valid[g] = 1'b1;
      sb_q[g].push_back(b);
      @(posedge clk_in);
      #1;
      valid[g] = 1'b0;
      acc = cyc;
   endtask

   // Returns at the first negedge where busy is low.
   task automatic wait_idle(input int g);
      int w;
      w = 0;
      do begin
         @(negedge clk_in);
         w++;
      end while (busy[g] === 1'b1 && w < 500);
      if (busy[g] !== 1'b0) begin
         checks++;
         errors++;
         $display("FAIL idle_timeout dut%0d: busy got %b, required 0", g, busy[g]);
      end
      #1;
   endtask

   task automatic test_reset();
      int a;
      #1 rst_in = 1'b1;
      #1;
      for (int g = 0; g < NDUT; g++) begin
         checks++;
         if (tx[g] !== 1'b1 || ready[g] !== 1'b1 || busy[g] !== 1'b0) begin
            errors++;
            $display("FAIL reset_values dut%0d: got tx=%b ready=%b busy=%b, required 1 1 0",
                     g, tx[g], ready[g], busy[g]);
         end
      end
      repeat (3) @(negedge clk_in);
      rst_in = 1'b0;
      @(posedge clk_in);
      #1;
      send(0, 8'h5A, a);
      repeat (13) @(posedge clk_in);
      #3;
      checks++;
      if (tx[0] !== 1'b0) begin
         errors++;
         $display("FAIL pre_reset_bit0 dut0: got tx=%b, required 0", tx[0]);
      end
      rst_in = 1'b1;
      #1;
      checks++;
      if (tx[0] !== 1'b1 || ready[0] !== 1'b1 || busy[0] !== 1'b0) begin
         errors++;
         $display("FAIL async_reset dut0: got tx=%b ready=%b busy=%b, required 1 1 0",
                  tx[0], ready[0], busy[0]);
      end
      sb_q[0].delete();
      repeat (3) @(negedge clk_in);
      rst_in = 1'b0;
   endtask

   task automatic test_8n1();
      int a, b0, f0;
      @(posedge clk_in);
      #1;
      b0 = busy_cnt[0];
      f0 = frames_done[0];
      send(0, 8'hA5, a);
      @(negedge clk_in);
      checks++;
      if (tx[0] !== 1'b0) begin
         errors++;
         $display("FAIL start_latency dut0: got tx=%b, required 0", tx[0]);
      end
      wait_idle(0);
      checks++;
      if (busy_cnt[0] - b0 != 100) begin
         errors++;
         $display("FAIL busy_8n1 dut0: got %0d busy cycles, required 100", busy_cnt[0] - b0);
      end
      checks++;
      if (frames_done[0] != f0 + 1) begin
         errors++;
         $display("FAIL frames_8n1 dut0: got %0d frames, required 1", frames_done[0] - f0);
      end
   endtask

   task automatic test_back_to_back();
      int a1, a2, b0, f0, low;
      logic prev_tx;
      @(posedge clk_in);
      #1;
      b0 = busy_cnt[0];
      f0 = frames_done[0];
      send(0, 8'h00, a1);
      repeat (30) @(posedge clk_in);
      #1;
      send(0, 8'hFF, a2);
      low     = 0;
      prev_tx = 1'bx;
      @(negedge clk_in);
      while (ready[0] === 1'b0 && low < 300) begin
         low++;
         prev_tx = tx[0];
         @(negedge clk_in);
      end
      checks++;
      if (low != a1 + 100 - a2) begin
         errors++;
         $display("FAIL ready_low dut0: got %0d low cycles, required %0d", low, a1 + 100 - a2);
      end
      checks++;
      if (prev_tx !== 1'b1 || tx[0] !== 1'b0) begin
         errors++;
         $display("FAIL no_gap dut0: got stop=%b start=%b, required 1 0", prev_tx, tx[0]);
      end
      wait_idle(0);
      checks++;
      if (busy_cnt[0] - b0 != 200) begin
         errors++;
         $display("FAIL busy_b2b dut0: got %0d busy cycles, required 200", busy_cnt[0] - b0);
      end
      checks++;
      if (frames_done[0] != f0 + 2) begin
         errors++;
         $display("FAIL frames_b2b dut0: got %0d frames, required 2", frames_done[0] - f0);
      end
   endtask

   task automatic test_parity();
      int a, b0;
      logic exp_par;
      for (int g = 1; g <= 2; g++) begin
         exp_par = (g == 1) ? 1'b1 : 1'b0;
         @(posedge clk_in);
         #1;
         b0 = busy_cnt[g];
         send(g, 8'h07, a);
         repeat (95) @(posedge clk_in);
         @(negedge clk_in);
         checks++;
         if (tx[g] !== exp_par) begin
            errors++;
            $display("FAIL parity_bit dut%0d: got %b, required %b", g, tx[g], exp_par);
         end
         wait_idle(g);
         checks++;
         if (busy_cnt[g] - b0 != 110) begin
            errors++;
            $display("FAIL busy_parity dut%0d: got %0d busy cycles, required 110",
                     g, busy_cnt[g] - b0);
         end
      end
   endtask

   task automatic test_two_stop();
      int a, b0;
      @(posedge clk_in);
      #1;
      b0 = busy_cnt[3];
      send(3, 8'h55, a);
      repeat (100) @(posedge clk_in);
      @(negedge clk_in);
      checks++;
      if (tx[3] !== 1'b1 || busy[3] !== 1'b1) begin
         errors++;
         $display("FAIL stop1 dut3: got tx=%b busy=%b, required 1 1", tx[3], busy[3]);
      end
      repeat (9) @(negedge clk_in);
      checks++;
      if (tx[3] !== 1'b1 || busy[3] !== 1'b1) begin
         errors++;
         $display("FAIL stop2_end dut3: got tx=%b busy=%b, required 1 1", tx[3], busy[3]);
      end
      @(negedge clk_in);
      checks++;
      if (busy[3] !== 1'b0 || tx[3] !== 1'b1) begin
         errors++;
         $display("FAIL idle_after_2stop dut3: got busy=%b tx=%b, required 0 1", busy[3], tx[3]);
      end
      #1;
      checks++;
      if (busy_cnt[3] - b0 != 110) begin
         errors++;
         $display("FAIL busy_2stop dut3: got %0d busy cycles, required 110", busy_cnt[3] - b0);
      end
   endtask

   task automatic test_reset_mid_frame();
      int a1, a2, a3, b0, f0;
      @(posedge clk_in);
      #1;
      send(0, 8'h3C, a1);
      send(0, 8'h81, a2);
      repeat (43) @(posedge clk_in);
      #3;
      checks++;
      if (ready[0] !== 1'b0) begin
         errors++;
         $display("FAIL hold_loaded dut0: got ready=%b, required 0", ready[0]);
      end
      rst_in = 1'b1;
      #1;
      checks++;
      if (tx[0] !== 1'b1 || ready[0] !== 1'b1 || busy[0] !== 1'b0) begin
         errors++;
         $display("FAIL reset_mid_frame dut0: got tx=%b ready=%b busy=%b, required 1 1 0",
                  tx[0], ready[0], busy[0]);
      end
      sb_q[0].delete();
      repeat (3) @(negedge clk_in);
      rst_in = 1'b0;
      @(posedge clk_in);
      #1;
      b0 = busy_cnt[0];
      f0 = frames_done[0];
      repeat (150) @(posedge clk_in);
      #1;
      checks++;
      if (busy_cnt[0] != b0) begin
         errors++;
         $display("FAIL discarded_hold dut0: got %0d busy cycles, required 0", busy_cnt[0] - b0);
      end
      send(0, 8'hC3, a3);
      wait_idle(0);
      checks++;
      if (frames_done[0] != f0 + 1) begin
         errors++;
         $display("FAIL frame_after_reset dut0: got %0d frames, required 1", frames_done[0] - f0);
      end
   endtask

   initial begin
      for (int g = 0; g < NDUT; g++) valid[g] = 1'b0;
      test_reset();
      test_8n1();
      test_back_to_back();
      test_parity();
      test_two_stop();
      test_reset_mid_frame();
      repeat (5) @(posedge clk_in);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
